// File: rtl/udma_mram_pkg.sv
// Shared definitions for the uDMA <-> MRAM size converters: TX state encoding,
// MRAM word geometry and byte-enable patterns.
package udma_mram_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL_LO = 3'd1,
    FILL_HI = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } tx_state_e;

  localparam int          MRAM_WORD_BYTES = 8;
  localparam int          BEAT_BYTES      = 4;
  localparam int          MRAM_ADDR_W     = 16;
  localparam logic [7:0]  BE_LO           = 8'h0F;
  localparam logic [7:0]  BE_ALL          = 8'hFF;

endpackage

// File: rtl/size_conv_tx_32_to_64.sv
// TX size converter: pops 32-bit beats from the TX FIFO, packs pairs into
// 64-bit MRAM words and writes them with a req/gnt handshake, then pulses eot.
module size_conv_tx_32_to_64
  import udma_mram_pkg::*;
#(
  parameter int TRANS_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_cmd_req_i,
  output logic                   push_cmd_gnt_o,
  input  logic [MRAM_ADDR_W-1:0] data_tx_addr_i,
  input  logic [TRANS_SIZE-1:0]  data_tx_size_i,
  input  logic [31:0]            data_tx_wdata_i,
  input  logic                   data_tx_valid_i,
  output logic                   data_tx_ready_o,
  output logic [MRAM_ADDR_W-1:0] data_tx_waddr_o,
  output logic [63:0]            data_tx_wdata_o,
  output logic [7:0]             data_tx_be_o,
  output logic                   data_tx_req_o,
  input  logic                   data_tx_gnt_i,
  output logic                   data_tx_clk_en_o,
  output logic                   data_tx_eot_o,
  output logic                   pending_o,
  input  logic                   NVR_i,
  input  logic                   TMEN_i,
  input  logic                   AREF_i,
  output logic                   mram_NVR_o,
  output logic                   mram_TMEN_o,
  output logic                   mram_AREF_o
);

  localparam logic [TRANS_SIZE-1:0] BEAT_STEP = TRANS_SIZE'(BEAT_BYTES);

  tx_state_e              cs_q, cs_d;
  logic [MRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [TRANS_SIZE-1:0]  rem_q, rem_d;
  logic [31:0]            lo_q, lo_d;
  logic [31:0]            hi_q, hi_d;
  logic [7:0]             be_q, be_d;
  logic                   nvr_q, nvr_d;
  logic                   tmen_q, tmen_d;
  logic                   aref_q, aref_d;

  // Transfers are whole 32-bit beats; the byte offset within a beat is dropped.
  logic unused_size_bits;
  assign unused_size_bits = ^data_tx_size_i[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q   <= IDLE;
      addr_q <= '0;
      rem_q  <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      be_q   <= '0;
      nvr_q  <= 1'b0;
      tmen_q <= 1'b0;
      aref_q <= 1'b0;
    end else begin
      cs_q   <= cs_d;
      addr_q <= addr_d;
      rem_q  <= rem_d;
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      be_q   <= be_d;
      nvr_q  <= nvr_d;
      tmen_q <= tmen_d;
      aref_q <= aref_d;
    end
  end

  always_comb begin
    cs_d             = cs_q;
    addr_d           = addr_q;
    rem_d            = rem_q;
    lo_d             = lo_q;
    hi_d             = hi_q;
    be_d             = be_q;
    nvr_d            = nvr_q;
    tmen_d           = tmen_q;
    aref_d           = aref_q;
    push_cmd_gnt_o   = 1'b0;
    data_tx_ready_o  = 1'b0;
    data_tx_waddr_o  = '0;
    data_tx_wdata_o  = '0;
    data_tx_be_o     = '0;
    data_tx_req_o    = 1'b0;
    data_tx_clk_en_o = 1'b0;
    data_tx_eot_o    = 1'b0;

    unique case (cs_q)
      IDLE: begin
        push_cmd_gnt_o = push_cmd_req_i;
        if (push_cmd_req_i) begin
          addr_d = data_tx_addr_i;
          rem_d  = {data_tx_size_i[TRANS_SIZE-1:2], 2'b00};
          nvr_d  = NVR_i;
          tmen_d = TMEN_i;
          aref_d = AREF_i;
          // A sub-beat size still completes the handshake with an eot, just no write.
          if (data_tx_size_i[TRANS_SIZE-1:2] == '0) begin
            cs_d = DONE;
          end else begin
            cs_d = FILL_LO;
          end
        end
      end

      FILL_LO: begin
        data_tx_ready_o = 1'b1;
        if (data_tx_valid_i) begin
          lo_d  = data_tx_wdata_i;
          rem_d = rem_q - BEAT_STEP;
          if (rem_q == BEAT_STEP) begin
            hi_d = '0;
            be_d = BE_LO;
            cs_d = WRITE;
          end else begin
            cs_d = FILL_HI;
          end
        end
      end

      FILL_HI: begin
        data_tx_ready_o = 1'b1;
        if (data_tx_valid_i) begin
          hi_d  = data_tx_wdata_i;
          rem_d = rem_q - BEAT_STEP;
          be_d  = BE_ALL;
          cs_d  = WRITE;
        end
      end

      WRITE: begin
        data_tx_req_o   = 1'b1;
        data_tx_waddr_o = addr_q;
        data_tx_wdata_o = {hi_q, lo_q};
        data_tx_be_o    = be_q;
        if (data_tx_gnt_i) begin
          data_tx_clk_en_o = 1'b1;
          addr_d           = addr_q + 1'b1;
          cs_d             = (rem_q == '0) ? DONE : FILL_LO;
        end
      end

      DONE: begin
        data_tx_eot_o = 1'b1;
        cs_d          = IDLE;
      end

      default: begin
        cs_d = IDLE;
      end
    endcase
  end

  assign pending_o   = push_cmd_req_i | (cs_q != IDLE);
  assign mram_NVR_o  = nvr_q;
  assign mram_TMEN_o = tmen_q;
  assign mram_AREF_o = aref_q;

endmodule

// File: tb/tb_size_conv_tx_32_to_64.sv
// Directed bench for size_conv_tx_32_to_64: FIFO source and MRAM sink models
// on the falling edge, command sequencing and checks from the main thread.
module tb_size_conv_tx_32_to_64;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_cmd_req_i;
  logic        push_cmd_gnt_o;
  logic [15:0] data_tx_addr_i;
  logic [15:0] data_tx_size_i;
  logic [31:0] data_tx_wdata_i;
  logic        data_tx_valid_i;
  logic        data_tx_ready_o;
  logic [15:0] data_tx_waddr_o;
  logic [63:0] data_tx_wdata_o;
  logic [7:0]  data_tx_be_o;
  logic        data_tx_req_o;
  logic        data_tx_gnt_i;
  logic        data_tx_clk_en_o;
  logic        data_tx_eot_o;
  logic        pending_o;
  logic        NVR_i, TMEN_i, AREF_i;
  logic        mram_NVR_o, mram_TMEN_o, mram_AREF_o;

  always #5 clk = ~clk;

  size_conv_tx_32_to_64 #(.TRANS_SIZE(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .push_cmd_req_i   (push_cmd_req_i),
    .push_cmd_gnt_o   (push_cmd_gnt_o),
    .data_tx_addr_i   (data_tx_addr_i),
    .data_tx_size_i   (data_tx_size_i),
    .data_tx_wdata_i  (data_tx_wdata_i),
    .data_tx_valid_i  (data_tx_valid_i),
    .data_tx_ready_o  (data_tx_ready_o),
    .data_tx_waddr_o  (data_tx_waddr_o),
    .data_tx_wdata_o  (data_tx_wdata_o),
    .data_tx_be_o     (data_tx_be_o),
    .data_tx_req_o    (data_tx_req_o),
    .data_tx_gnt_i    (data_tx_gnt_i),
    .data_tx_clk_en_o (data_tx_clk_en_o),
    .data_tx_eot_o    (data_tx_eot_o),
    .pending_o        (pending_o),
    .NVR_i            (NVR_i),
    .TMEN_i           (TMEN_i),
    .AREF_i           (AREF_i),
    .mram_NVR_o       (mram_NVR_o),
    .mram_TMEN_o      (mram_TMEN_o),
    .mram_AREF_o      (mram_AREF_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO source / MRAM sink state (written only by the driver process, except
  // beats/n_beats/valid_toggle/gnt_en which only the main thread writes).
  logic [31:0] beats [64];
  int          n_beats      = 0;
  int          beat_idx     = 0;
  bit          valid_toggle = 1'b0;
  bit          gnt_en       = 1'b1;
  int          cyc          = 0;
  int          pop_cnt      = 0;
  int          wr_cnt       = 0;
  int          eot_cnt      = 0;
  int          clk_en_cnt   = 0;
  int          cmd_cyc      = 0;
  int          eot_cyc      = 0;
  bit          pop_sched    = 1'b0;
  bit          prev_stall   = 1'b0;
  logic [15:0] prev_waddr;
  logic [63:0] prev_wdata;
  logic [7:0]  prev_be;
  logic [15:0] wr_addr [32];
  logic [63:0] wr_data [32];
  logic [7:0]  wr_be   [32];
  int          wr_cyc  [32];

  initial begin
    data_tx_valid_i = 1'b0;
    data_tx_wdata_i = '0;
    data_tx_gnt_i   = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pop_sched) begin
        pop_cnt++;
        beat_idx++;
      end
      data_tx_valid_i = (beat_idx < n_beats) && (!valid_toggle || (cyc % 2 == 1));
      data_tx_wdata_i = (beat_idx < n_beats) ? beats[beat_idx] : 32'hDEADBEEF;
      data_tx_gnt_i   = gnt_en;
      #1;
      pop_sched = data_tx_valid_i && data_tx_ready_o;
      if (push_cmd_gnt_o) cmd_cyc = cyc;
      if (data_tx_eot_o) begin
        eot_cnt++;
        eot_cyc = cyc;
      end
      if (data_tx_clk_en_o) clk_en_cnt++;
      if (data_tx_req_o) begin
        check_val("ready_in_write", data_tx_ready_o, 1'b0);
        if (prev_stall) begin
          check_val("stall_waddr", data_tx_waddr_o, prev_waddr);
          check_val("stall_wdata", data_tx_wdata_o, prev_wdata);
          check_val("stall_be", data_tx_be_o, prev_be);
        end
        if (!data_tx_gnt_i) begin
          check_val("stall_clk_en", data_tx_clk_en_o, 1'b0);
        end else if (wr_cnt < 32) begin
          wr_addr[wr_cnt] = data_tx_waddr_o;
          wr_data[wr_cnt] = data_tx_wdata_o;
          wr_be[wr_cnt]   = data_tx_be_o;
          wr_cyc[wr_cnt]  = cyc;
          wr_cnt++;
        end
      end
      prev_stall = data_tx_req_o && !data_tx_gnt_i;
      prev_waddr = data_tx_waddr_o;
      prev_wdata = data_tx_wdata_o;
      prev_be    = data_tx_be_o;
    end
  end

  task automatic add_beat(input logic [31:0] b);
    beats[n_beats] = b;
    n_beats++;
  endtask

  task automatic send_cmd(input logic [15:0] addr, input logic [15:0] size,
                          input logic nvr, input logic tmen, input logic aref);
    @(posedge clk); #2;
    push_cmd_req_i = 1'b1;
    data_tx_addr_i = addr;
    data_tx_size_i = size;
    NVR_i          = nvr;
    TMEN_i         = tmen;
    AREF_i         = aref;
    #1;
    check_val("cmd_gnt", push_cmd_gnt_o, 1'b1);
    @(posedge clk); #2;
    push_cmd_req_i = 1'b0;
  endtask

  // Waits (bounded) for one eot after base, then idles to expose any extra pulse.
  task automatic wait_eot(input int base, input string tag);
    for (int i = 0; i < 300 && eot_cnt == base; i++) begin
      @(posedge clk); #2;
    end
    repeat (4) begin
      @(posedge clk); #2;
    end
    check_val(tag, 64'(eot_cnt - base), 64'd1);
  endtask

  int wb, pb, eb, cb;

  task automatic snap();
    wb = wr_cnt;
    pb = pop_cnt;
    eb = eot_cnt;
    cb = clk_en_cnt;
  endtask

  initial begin
    rst            = 1'b1;
    push_cmd_req_i = 1'b0;
    data_tx_addr_i = '0;
    data_tx_size_i = '0;
    NVR_i          = 1'b0;
    TMEN_i         = 1'b0;
    AREF_i         = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_val("rst_req", data_tx_req_o, 1'b0);
    check_val("rst_ready", data_tx_ready_o, 1'b0);
    check_val("rst_eot", data_tx_eot_o, 1'b0);
    check_val("rst_outs", {data_tx_waddr_o, data_tx_be_o, data_tx_clk_en_o, pending_o, push_cmd_gnt_o}, '0);
    check_val("rst_wdata", data_tx_wdata_o, 64'h0);
    check_val("rst_mode", {mram_NVR_o, mram_TMEN_o, mram_AREF_o}, 3'b000);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // 1: two full words
    snap();
    add_beat(32'h11111111); add_beat(32'h22222222); add_beat(32'h33333333); add_beat(32'h44444444);
    send_cmd(16'h0010, 16'd16, 1'b0, 1'b0, 1'b0);
    wait_eot(eb, "t1_eot_count");
    check_val("t1_writes", 64'(wr_cnt - wb), 64'd2);
    check_val("t1_addr0", wr_addr[wb], 16'h0010);
    check_val("t1_data0", wr_data[wb], 64'h22222222_11111111);
    check_val("t1_be0", wr_be[wb], 8'hFF);
    check_val("t1_addr1", wr_addr[wb+1], 16'h0011);
    check_val("t1_data1", wr_data[wb+1], 64'h44444444_33333333);
    check_val("t1_be1", wr_be[wb+1], 8'hFF);
    check_val("t1_word_period", 64'(wr_cyc[wb+1] - wr_cyc[wb]), 64'd3);
    check_val("t1_eot_timing", 64'(eot_cyc - wr_cyc[wb+1]), 64'd1);
    check_val("t1_clk_en", 64'(clk_en_cnt - cb), 64'd2);
    check_val("t1_pops", 64'(pop_cnt - pb), 64'd4);
    $display("t1 addr=0010 size=16 writes=%0d pops=%0d", wr_cnt - wb, pop_cnt - pb);

    // 2: odd beat count, half word at the tail
    snap();
    add_beat(32'h11111111); add_beat(32'h22222222); add_beat(32'h33333333);
    send_cmd(16'h0010, 16'd12, 1'b0, 1'b0, 1'b0);
    wait_eot(eb, "t2_eot_count");
    check_val("t2_writes", 64'(wr_cnt - wb), 64'd2);
    check_val("t2_data0", wr_data[wb], 64'h22222222_11111111);
    check_val("t2_addr1", wr_addr[wb+1], 16'h0011);
    check_val("t2_data1", wr_data[wb+1], 64'h00000000_33333333);
    check_val("t2_be1", wr_be[wb+1], 8'h0F);
    check_val("t2_pops", 64'(pop_cnt - pb), 64'd3);
    $display("t2 addr=0010 size=12 writes=%0d pops=%0d", wr_cnt - wb, pop_cnt - pb);

    // 3: grant stall plus a command attempt while busy
    snap();
    add_beat(32'hAAAAAAAA); add_beat(32'hBBBBBBBB);
    send_cmd(16'h0100, 16'd8, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 50 && !data_tx_req_o; i++) begin
      @(posedge clk); #2;
    end
    check_val("t3_req_seen", data_tx_req_o, 1'b1);
    gnt_en         = 1'b0;
    push_cmd_req_i = 1'b1;
    #1;
    check_val("t3_busy_gnt", push_cmd_gnt_o, 1'b0);
    check_val("t3_busy_pending", pending_o, 1'b1);
    @(posedge clk); #2;
    push_cmd_req_i = 1'b0;
    repeat (5) begin
      @(posedge clk); #2;
    end
    check_val("t3_stall_req", data_tx_req_o, 1'b1);
    check_val("t3_stall_nowr", 64'(wr_cnt - wb), 64'd0);
    check_val("t3_stall_pops", 64'(pop_cnt - pb), 64'd2);
    gnt_en = 1'b1;
    wait_eot(eb, "t3_eot_count");
    check_val("t3_writes", 64'(wr_cnt - wb), 64'd1);
    check_val("t3_addr", wr_addr[wb], 16'h0100);
    check_val("t3_data", wr_data[wb], 64'hBBBBBBBB_AAAAAAAA);
    check_val("t3_be", wr_be[wb], 8'hFF);
    $display("t3 addr=0100 size=8 stall writes=%0d", wr_cnt - wb);

    // 4: address wrap with a gappy FIFO
    snap();
    valid_toggle = 1'b1;
    add_beat(32'hC0C0C0C0); add_beat(32'hC1C1C1C1); add_beat(32'hC2C2C2C2); add_beat(32'hC3C3C3C3);
    send_cmd(16'hFFFF, 16'd16, 1'b0, 1'b0, 1'b0);
    wait_eot(eb, "t4_eot_count");
    valid_toggle = 1'b0;
    check_val("t4_writes", 64'(wr_cnt - wb), 64'd2);
    check_val("t4_addr0", wr_addr[wb], 16'hFFFF);
    check_val("t4_data0", wr_data[wb], 64'hC1C1C1C1_C0C0C0C0);
    check_val("t4_addr1", wr_addr[wb+1], 16'h0000);
    check_val("t4_data1", wr_data[wb+1], 64'hC3C3C3C3_C2C2C2C2);
    check_val("t4_pops", 64'(pop_cnt - pb), 64'd4);
    $display("t4 addr=FFFF size=16 toggled writes=%0d pops=%0d", wr_cnt - wb, pop_cnt - pb);

    // 5a: empty transfer
    snap();
    send_cmd(16'h0020, 16'd0, 1'b0, 1'b0, 1'b0);
    wait_eot(eb, "t5a_eot_count");
    check_val("t5a_writes", 64'(wr_cnt - wb), 64'd0);
    check_val("t5a_eot_timing", 64'(eot_cyc - cmd_cyc), 64'd1);
    $display("t5a size=0 writes=%0d", wr_cnt - wb);

    // 5b: size 7 rounds down to one beat
    snap();
    add_beat(32'h55555555);
    send_cmd(16'h0020, 16'd7, 1'b0, 1'b0, 1'b0);
    wait_eot(eb, "t5b_eot_count");
    check_val("t5b_writes", 64'(wr_cnt - wb), 64'd1);
    check_val("t5b_data", wr_data[wb], 64'h00000000_55555555);
    check_val("t5b_be", wr_be[wb], 8'h0F);
    check_val("t5b_pops", 64'(pop_cnt - pb), 64'd1);
    $display("t5b size=7 writes=%0d pops=%0d", wr_cnt - wb, pop_cnt - pb);

    // 6: reset after the first beat, then a normal transfer
    snap();
    add_beat(32'h77777777);
    send_cmd(16'h0030, 16'd16, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 50 && pop_cnt == pb; i++) begin
      @(posedge clk); #2;
    end
    check_val("t6_first_pop", 64'(pop_cnt - pb), 64'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_val("t6_rst_ctrl", {data_tx_req_o, data_tx_ready_o, data_tx_eot_o, data_tx_clk_en_o, pending_o}, 5'b0);
    check_val("t6_rst_mode", {mram_NVR_o, mram_TMEN_o, mram_AREF_o}, 3'b000);
    repeat (3) begin
      @(posedge clk); #2;
    end
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #2;
    end
    check_val("t6_no_eot", 64'(eot_cnt - eb), 64'd0);
    check_val("t6_no_write", 64'(wr_cnt - wb), 64'd0);
    snap();
    add_beat(32'h88888888); add_beat(32'h99999999);
    send_cmd(16'h0040, 16'd8, 1'b1, 1'b0, 1'b1);
    wait_eot(eb, "t6_eot_count");
    check_val("t6_writes", 64'(wr_cnt - wb), 64'd1);
    check_val("t6_addr", wr_addr[wb], 16'h0040);
    check_val("t6_data", wr_data[wb], 64'h99999999_88888888);
    check_val("t6_mode", {mram_NVR_o, mram_TMEN_o, mram_AREF_o}, 3'b101);
    $display("t6 reset mid-transfer then addr=0040 size=8 writes=%0d", wr_cnt - wb);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
